// File: rtl/dinterp_sched.sv
// Round-robin command scheduler feeding DINTERP: grants one requester at a time,
// pulses DATA_READY for one cycle, then holds DATA for HOLD cycles before the next grant.
module dinterp_sched #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 32,
    parameter int HOLD    = 4,
    localparam int GW     = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*DW-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [DW-1:0]         DATA,
    output logic                  DATA_READY,
    output logic [GW-1:0]         grant_id,
    output logic                  busy,
    output logic                  cmd_done
);

    typedef enum logic [1:0] {IDLE, ISSUE, SETTLE} state_t;

    state_t                       r_state, w_state_nxt;
    logic   [GW-1:0]              r_ptr;
    logic   [GW-1:0]              r_gid;
    logic   [7:0]                 r_cnt;
    logic   [DW-1:0]              r_data;
    logic                         r_dr;
    logic                         r_done;

    logic   [NUM_REQ-1:0][DW-1:0] w_req;
    logic   [GW-1:0]              w_win;
    logic   [GW-1:0]              w_idx;
    logic                         w_found;
    logic                         w_accept;
    logic                         w_settle_end;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_req[g] = req_data[g*DW +: DW];
    end

    // Search upward from the requester after the last winner, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = GW'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_accept     = rst_n && (r_state == IDLE) && enable && w_found;
    assign w_settle_end = (r_state == SETTLE) && (r_cnt == 8'd0);
    assign req_ready    = w_accept ? (NUM_REQ'(1) << w_win) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = ISSUE;
            ISSUE:   w_state_nxt = SETTLE;
            SETTLE:  if (r_cnt == 8'd0) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr  <= GW'(NUM_REQ - 1);
            r_gid  <= '0;
            r_cnt  <= 8'd0;
            r_data <= '0;
            r_dr   <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_dr   <= w_accept;
            r_done <= w_settle_end;
            if (w_accept) begin
                r_data <= w_req[w_win];
                r_gid  <= w_win;
                r_ptr  <= w_win;
            end
            if (r_state == ISSUE)
                r_cnt <= 8'(HOLD - 1);
            else if (r_state == SETTLE && r_cnt != 8'd0)
                r_cnt <= r_cnt - 8'd1;
        end
    end

    assign DATA       = r_data;
    assign DATA_READY = r_dr;
    assign grant_id   = r_gid;
    assign busy       = (r_state != IDLE);
    assign cmd_done   = r_done;

endmodule

// File: tb/tb_dinterp_sched.sv
// Bench for dinterp_sched: directed scenarios plus a randomized run against a
// cycles-since-accept reference model.
module tb_dinterp_sched;
    localparam int NUM_REQ = 4;
    localparam int DW      = 32;
    localparam int HOLD    = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  enable = 1'b0;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ*DW-1:0] req_data = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic [DW-1:0]         DATA;
    logic                  DATA_READY;
    logic [1:0]            grant_id;
    logic                  busy;
    logic                  cmd_done;

    dinterp_sched #(.NUM_REQ(NUM_REQ), .DW(DW), .HOLD(HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .req_valid(req_valid),
        .req_data(req_data), .req_ready(req_ready), .DATA(DATA),
        .DATA_READY(DATA_READY), .grant_id(grant_id), .busy(busy), .cmd_done(cmd_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    int q_grant[$];
    int q_time[$];
    int cnt_dr, cnt_done, n_multi, n_dchg, cyc;
    logic [NUM_REQ-1:0] sticky = '0;
    logic               prev_busy = 1'b0;
    logic [DW-1:0]      prev_data = '0;

    task automatic clear_log();
        q_grant.delete(); q_time.delete();
        cnt_dr = 0; cnt_done = 0; n_multi = 0; n_dchg = 0;
    endtask

    // One clock: observe mid-cycle, then requesters drop valid after their accept.
    task automatic step();
        logic [NUM_REQ-1:0] r;
        @(negedge clk);
        r = req_ready;
        if ($countones(r) > 1) n_multi++;
        for (int i = 0; i < NUM_REQ; i++)
            if (r[i]) begin q_grant.push_back(i); q_time.push_back(cyc); end
        if (DATA_READY) cnt_dr++;
        if (cmd_done) cnt_done++;
        if (prev_busy && busy && DATA !== prev_data) n_dchg++;
        prev_busy = busy; prev_data = DATA;
        @(posedge clk); #1;
        cyc++;
        req_valid = req_valid & ~(r & ~sticky);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; req_valid = '0; enable = 1'b1; sticky = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        prev_busy = 1'b0;
    endtask

    task automatic set_data(input int i, input logic [DW-1:0] d);
        req_data[i*DW +: DW] = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; req_valid = 4'b1111;
        repeat (2) @(posedge clk);
        #2;
        n_vec++; if (DATA !== 32'h0) begin n_err++; $display("FAIL rst_data got %h exp 0", DATA); end
        n_vec++; if (DATA_READY !== 1'b0) begin n_err++; $display("FAIL rst_dr got %b exp 0", DATA_READY); end
        n_vec++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL rst_gid got %0d exp 0", grant_id); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b exp 0", busy); end
        n_vec++; if (cmd_done !== 1'b0) begin n_err++; $display("FAIL rst_done got %b exp 0", cmd_done); end
        n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rst_ready got %b exp 0000", req_ready); end
        req_valid = '0;
        @(posedge clk); #1 rst_n = 1'b1;
        #2;
        n_vec++; if (busy !== 1'b0 || DATA_READY !== 1'b0) begin n_err++; $display("FAIL rst_release got busy=%b dr=%b exp 0 0", busy, DATA_READY); end
    endtask

    task automatic test_single();
        apply_reset(); clear_log();
        set_data(1, 32'h8040A4A4);
        req_valid = 4'b0010;
        #2;
        n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL single_ready got %b exp 0010", req_ready); end
        step();
        for (int k = 0; k <= HOLD + 2; k++) begin
            #2;
            n_vec++; if (DATA !== 32'h8040A4A4) begin n_err++; $display("FAIL single_data k=%0d got %h exp 8040a4a4", k, DATA); end
            n_vec++; if (DATA_READY !== (k == 0)) begin n_err++; $display("FAIL single_dr k=%0d got %b exp %b", k, DATA_READY, k == 0); end
            n_vec++; if (busy !== (k <= HOLD)) begin n_err++; $display("FAIL single_busy k=%0d got %b exp %b", k, busy, k <= HOLD); end
            n_vec++; if (cmd_done !== (k == HOLD + 1)) begin n_err++; $display("FAIL single_done k=%0d got %b exp %b", k, cmd_done, k == HOLD + 1); end
            n_vec++; if (grant_id !== 2'd1) begin n_err++; $display("FAIL single_gid k=%0d got %0d exp 1", k, grant_id); end
            step();
        end
        n_vec++; if (cnt_dr !== 1 || cnt_done !== 1) begin n_err++; $display("FAIL single_pulses got dr=%0d done=%0d exp 1 1", cnt_dr, cnt_done); end
    endtask

    task automatic test_all4();
        apply_reset(); clear_log();
        for (int i = 0; i < NUM_REQ; i++) set_data(i, 32'hA0000000 + i);
        req_valid = 4'b1111;
        repeat (4 * (HOLD + 2) + 4) step();
        n_vec++;
        if (q_grant.size() !== 4) begin n_err++; $display("FAIL all4_count got %0d exp 4", q_grant.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                n_vec++; if (q_grant[i] !== i) begin n_err++; $display("FAIL all4_order idx=%0d got %0d exp %0d", i, q_grant[i], i); end
            end
            for (int i = 1; i < 4; i++) begin
                n_vec++; if (q_time[i] - q_time[i-1] !== HOLD + 2) begin n_err++; $display("FAIL all4_spacing idx=%0d got %0d exp %0d", i, q_time[i] - q_time[i-1], HOLD + 2); end
            end
        end
        n_vec++; if (n_multi !== 0) begin n_err++; $display("FAIL all4_onehot got %0d multi exp 0", n_multi); end
        n_vec++; if (cnt_done !== 4) begin n_err++; $display("FAIL all4_done got %0d exp 4", cnt_done); end
        n_vec++; if (DATA !== 32'hA0000003) begin n_err++; $display("FAIL all4_lastdata got %h exp a0000003", DATA); end
    endtask

    task automatic test_fairness();
        apply_reset(); clear_log();
        set_data(0, 32'h11110000); set_data(2, 32'h22220000);
        sticky = 4'b0101; req_valid = 4'b0101;
        for (int t = 0; t < 200 && q_grant.size() < 8; t++) step();
        n_vec++; if (q_grant.size() < 8) begin n_err++; $display("FAIL fair_count got %0d exp 8", q_grant.size()); end
        for (int i = 0; i < q_grant.size() && i < 8; i++) begin
            n_vec++; if (q_grant[i] !== (i % 2) * 2) begin n_err++; $display("FAIL fair_order idx=%0d got %0d exp %0d", i, q_grant[i], (i % 2) * 2); end
        end
        sticky = '0; req_valid = '0;
        repeat (HOLD + 4) step();
    endtask

    task automatic test_enable();
        apply_reset(); clear_log();
        enable = 1'b0; req_valid = 4'b1111;
        repeat (20) step();
        n_vec++; if (q_grant.size() !== 0) begin n_err++; $display("FAIL en_gate_ready got %0d accepts exp 0", q_grant.size()); end
        n_vec++; if (cnt_dr !== 0) begin n_err++; $display("FAIL en_gate_dr got %0d pulses exp 0", cnt_dr); end
        set_data(0, 32'h0BADF00D);
        req_valid = 4'b0001; enable = 1'b1;
        for (int t = 0; t < 10 && q_grant.size() < 1; t++) step();
        n_vec++; if (q_grant.size() !== 1) begin n_err++; $display("FAIL en_first_accept got %0d exp 1", q_grant.size()); end
        step(); step();
        enable = 1'b0; req_valid = 4'b1110;
        repeat (12) step();
        n_vec++; if (cnt_done !== 1) begin n_err++; $display("FAIL en_drop_done got %0d exp 1", cnt_done); end
        n_vec++; if (q_grant.size() !== 1) begin n_err++; $display("FAIL en_drop_noaccept got %0d exp 1", q_grant.size()); end
        enable = 1'b1;
        for (int t = 0; t < 10 && q_grant.size() < 2; t++) step();
        n_vec++;
        if (q_grant.size() !== 2) begin n_err++; $display("FAIL en_resume got %0d accepts exp 2", q_grant.size()); end
        else if (q_grant[1] !== 1) begin n_err++; $display("FAIL en_resume got id %0d exp 1", q_grant[1]); end
        req_valid = '0;
        repeat (HOLD + 4) step();
    endtask

    task automatic test_reset_mid();
        apply_reset(); clear_log();
        set_data(2, 32'hC0FFEE22);
        req_valid = 4'b0100;
        step(); step(); step();
        rst_n = 1'b0;
        #1;
        n_vec++; if (DATA !== 32'h0) begin n_err++; $display("FAIL mid_data got %h exp 0", DATA); end
        n_vec++; if (DATA_READY !== 1'b0) begin n_err++; $display("FAIL mid_dr got %b exp 0", DATA_READY); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy got %b exp 0", busy); end
        n_vec++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL mid_gid got %0d exp 0", grant_id); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        prev_busy = 1'b0;
        clear_log();
        repeat (HOLD + 3) step();
        n_vec++; if (cnt_done !== 0 || cnt_dr !== 0) begin n_err++; $display("FAIL mid_nodone got done=%0d dr=%0d exp 0 0", cnt_done, cnt_dr); end
        set_data(1, 32'h11111111); set_data(2, 32'h22222222);
        req_valid = 4'b0110;
        for (int t = 0; t < 10 && q_grant.size() < 1; t++) step();
        n_vec++;
        if (q_grant.size() < 1) begin n_err++; $display("FAIL mid_regrant got no accept exp id 1"); end
        else if (q_grant[0] !== 1) begin n_err++; $display("FAIL mid_regrant got id %0d exp 1", q_grant[0]); end
        req_valid = '0;
        repeat (HOLD + 4) step();
    endtask

    task automatic test_read();
        clear_log();
        set_data(3, 32'h0040A4A4);
        req_valid = 4'b1000;
        for (int t = 0; t < 10 && q_grant.size() < 1; t++) step();
        n_vec++; if (q_grant.size() !== 1) begin n_err++; $display("FAIL read_accept got %0d exp 1", q_grant.size()); end
        repeat (HOLD + 2) step();
        n_vec++; if (cnt_done !== 1) begin n_err++; $display("FAIL read_done got %0d exp 1", cnt_done); end
        repeat (5) step();
        #2;
        n_vec++; if (DATA !== 32'h0040A4A4) begin n_err++; $display("FAIL read_retain got %h exp 0040a4a4", DATA); end
        n_vec++; if (grant_id !== 2'd3) begin n_err++; $display("FAIL read_gid got %0d exp 3", grant_id); end
        n_vec++; if (n_dchg !== 0) begin n_err++; $display("FAIL read_stable got %0d changes exp 0", n_dchg); end
    endtask

    // Model: cycles elapsed since the last accept decide every output.
    task automatic test_random();
        int m_k, m_last, m_gid, w;
        logic [DW-1:0]      m_data;
        logic [NUM_REQ-1:0] v, acc, exp_rr;
        apply_reset();
        m_k = 1000; m_last = NUM_REQ - 1; m_gid = 0; m_data = '0; v = '0; acc = '0;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc[i]) v[i] = 1'b0;
                if (!v[i]) begin
                    if ($urandom_range(0, 2) == 0) begin v[i] = 1'b1; req_data[i*DW +: DW] = $urandom; end
                end else if ($urandom_range(0, 15) == 0) v[i] = 1'b0;
            end
            req_valid = v;
            enable = ($urandom_range(0, 4) != 0);
            #2;
            w = -1;
            if (m_k > HOLD && enable)
                for (int k = 1; k <= NUM_REQ; k++)
                    if (w < 0 && v[(m_last + k) % NUM_REQ]) w = (m_last + k) % NUM_REQ;
            exp_rr = '0;
            if (w >= 0) exp_rr[w] = 1'b1;
            n_vec++; if (req_ready !== exp_rr) begin n_err++; $display("FAIL rnd_ready c=%0d got %b exp %b", c, req_ready, exp_rr); end
            n_vec++; if (DATA !== m_data) begin n_err++; $display("FAIL rnd_data c=%0d got %h exp %h", c, DATA, m_data); end
            n_vec++; if (DATA_READY !== (m_k == 0)) begin n_err++; $display("FAIL rnd_dr c=%0d got %b exp %b", c, DATA_READY, m_k == 0); end
            n_vec++; if (busy !== (m_k <= HOLD)) begin n_err++; $display("FAIL rnd_busy c=%0d got %b exp %b", c, busy, m_k <= HOLD); end
            n_vec++; if (cmd_done !== (m_k == HOLD + 1)) begin n_err++; $display("FAIL rnd_done c=%0d got %b exp %b", c, cmd_done, m_k == HOLD + 1); end
            n_vec++; if (int'(grant_id) !== m_gid) begin n_err++; $display("FAIL rnd_gid c=%0d got %0d exp %0d", c, grant_id, m_gid); end
            @(posedge clk); #1;
            acc = exp_rr;
            if (w >= 0) begin
                m_last = w; m_gid = w; m_data = req_data[w*DW +: DW]; m_k = 0;
            end else if (m_k < 1000) m_k++;
        end
        req_valid = '0; enable = 1'b1;
        repeat (HOLD + 4) @(posedge clk);
    endtask

    initial begin
        cyc = 0;
        clear_log();
        test_reset();
        test_single();
        test_all4();
        test_fairness();
        test_enable();
        test_reset_mid();
        test_read();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
